// File: rtl/int_request_ctrl.sv
// int_request_ctrl: interrupt source side of the CPU interrupt interface.
// Collects maskable IRQ lines and a non-maskable source, drives INT/NMI to the
// Controller, tracks acknowledge / end-of-interrupt and supplies the handler vector.
// Build option: define IRQ_EDGE_EN for edge-detected IRQ lines; the default build
// treats IRQ lines as level sensitive.
module int_request_ctrl #(
    parameter int unsigned N_IRQ = 4,
    parameter int unsigned VEC_W = 3
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [N_IRQ-1:0] IRQ,
    input  logic             NMI_SRC,
    input  logic             INT_FLAG,
    input  logic             MASK_WE,
    input  logic [N_IRQ-1:0] MASK_DIN,
    input  logic             INT_ACK,
    input  logic             EOI,
    output logic             INT,
    output logic             NMI,
    output logic [VEC_W-1:0] INT_VEC,
    output logic             IN_SERVICE
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ_NMI = 2'd1;
    localparam logic [1:0] S_REQ_INT = 2'd2;
    localparam logic [1:0] S_SERVICE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] eligible;
    logic             any_eligible;
    logic [VEC_W-1:0] sel_vec;
    logic             nmi_src_q;
    logic             nmi_pend;
    logic             nmi_clr;

    // Input sampling: IRQ and NMI_SRC registered copies for edge detection / sampling
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            irq_q     <= '0;
            nmi_src_q <= 1'b0;
        end else begin
            irq_q     <= IRQ;
            nmi_src_q <= NMI_SRC;
        end
    end

    // Mask register: all sources masked out of reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mask <= '1;
        end else if (MASK_WE) begin
            mask <= MASK_DIN;
        end
    end

    assign nmi_clr = (state == S_REQ_NMI) && INT_ACK;

    // NMI pending flag: set on a rising edge of NMI_SRC, cleared when the NMI is acked
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            nmi_pend <= 1'b0;
        end else begin
            nmi_pend <= (nmi_pend & ~nmi_clr) | (NMI_SRC & ~nmi_src_q);
        end
    end

`ifdef IRQ_EDGE_EN
    logic [N_IRQ-1:0] ack_clr;

    // Decode which pending bit the acknowledged vector belongs to
    always_comb begin
        ack_clr = '0;
        if ((state == S_REQ_INT) && INT_ACK && any_eligible) begin
            for (int unsigned k = 0; k < N_IRQ; k++) begin
                if (sel_vec == VEC_W'(k + 1)) begin
                    ack_clr[k] = 1'b1;
                end
            end
        end
    end

    // Edge-mode pending: a new edge in the ack cycle wins over the clear
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~ack_clr) | (IRQ & ~irq_q);
        end
    end
`else
    // Level mode: the sampled line is the request; dropping it withdraws the request
    assign pending = irq_q;
`endif

    assign eligible = pending & ~mask & {N_IRQ{INT_FLAG}};

    // Fixed priority: lowest eligible index wins, vector is index+1
    always_comb begin
        any_eligible = 1'b0;
        sel_vec      = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (eligible[i] && !any_eligible) begin
                any_eligible = 1'b1;
                sel_vec      = VEC_W'(i + 1);
            end
        end
    end

    // Next-state logic; NMI requests pre-empt a not-yet-acked maskable request
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (nmi_pend) begin
                    state_nxt = S_REQ_NMI;
                end else if (any_eligible) begin
                    state_nxt = S_REQ_INT;
                end
            end
            S_REQ_NMI: begin
                if (INT_ACK) begin
                    state_nxt = S_SERVICE;
                end
            end
            S_REQ_INT: begin
                if (INT_ACK && any_eligible) begin
                    state_nxt = S_SERVICE;
                end else if (nmi_pend) begin
                    state_nxt = S_REQ_NMI;
                end else if (!any_eligible) begin
                    state_nxt = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (nmi_pend) begin
                    state_nxt = S_REQ_NMI;
                end else if (EOI) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register plus in-service vector and flag tracking
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_IDLE;
            INT_VEC    <= '0;
            IN_SERVICE <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_REQ_NMI: begin
                    if (INT_ACK) begin
                        INT_VEC    <= '0;
                        IN_SERVICE <= 1'b1;
                    end
                end
                S_REQ_INT: begin
                    if (INT_ACK && any_eligible) begin
                        INT_VEC    <= sel_vec;
                        IN_SERVICE <= 1'b1;
                    end
                end
                S_SERVICE: begin
                    if (EOI) begin
                        IN_SERVICE <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign INT = (state == S_REQ_INT);
    assign NMI = (state == S_REQ_NMI);

endmodule

// File: tb/tb_int_request_ctrl.sv
// Self-checking bench for int_request_ctrl: directed scenarios plus a randomized
// run against a behavioural model of the interrupt request rules.
module tb_int_request_ctrl;

    logic       Clk;
    logic       Rst_n;
    logic [3:0] IRQ;
    logic       NMI_SRC;
    logic       INT_FLAG;
    logic       MASK_WE;
    logic [3:0] MASK_DIN;
    logic       INT_ACK;
    logic       EOI;
    logic       INT;
    logic       NMI;
    logic [2:0] INT_VEC;
    logic       IN_SERVICE;

    logic [5:0] st;
    int         checks;
    int         errors;

    int_request_ctrl #(.N_IRQ(4), .VEC_W(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .IRQ(IRQ), .NMI_SRC(NMI_SRC), .INT_FLAG(INT_FLAG),
        .MASK_WE(MASK_WE), .MASK_DIN(MASK_DIN), .INT_ACK(INT_ACK), .EOI(EOI),
        .INT(INT), .NMI(NMI), .INT_VEC(INT_VEC), .IN_SERVICE(IN_SERVICE)
    );

    // status word: {INT, NMI, IN_SERVICE, INT_VEC}
    assign st = {INT, NMI, IN_SERVICE, INT_VEC};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_dut;
        Rst_n = 1'b0; IRQ = '0; NMI_SRC = 1'b0; INT_FLAG = 1'b0;
        MASK_WE = 1'b0; MASK_DIN = '0; INT_ACK = 1'b0; EOI = 1'b0;
        tick;
        tick;
        Rst_n = 1'b1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        MASK_WE = 1'b1; MASK_DIN = m;
        tick;
        MASK_WE = 1'b0;
    endtask

    task automatic pulse_ack;
        INT_ACK = 1'b1;
        tick;
        INT_ACK = 1'b0;
    endtask

    task automatic pulse_eoi;
        EOI = 1'b1;
        tick;
        EOI = 1'b0;
    endtask

    task automatic test_reset;
        reset_dut;
        checks++;
        if (st !== 6'b000000) begin
            errors++; $display("FAIL reset_state: got %b expected %b", st, 6'b000000);
        end
    endtask

    task automatic test_basic;
        reset_dut;
        write_mask(4'b1110);
        INT_FLAG = 1'b1; IRQ = 4'b0001;
        tick;
        checks++;
        if (INT !== 1'b0) begin
            errors++; $display("FAIL basic_latency1: got INT=%b expected 0", INT);
        end
        tick;
        checks++;
        if (st !== 6'b100000) begin
            errors++; $display("FAIL basic_int: got %b expected %b", st, 6'b100000);
        end
        pulse_ack;
        checks++;
        if (st !== 6'b001001) begin
            errors++; $display("FAIL basic_ack: got %b expected %b", st, 6'b001001);
        end
        IRQ = 4'b0000;
        pulse_eoi;
        checks++;
        if (st[5:3] !== 3'b000) begin
            errors++; $display("FAIL basic_eoi: got %b expected 000", st[5:3]);
        end
        tick; tick;
        checks++;
        if (st[5:3] !== 3'b000) begin
            errors++; $display("FAIL basic_quiet: got %b expected 000", st[5:3]);
        end
    endtask

    task automatic test_priority;
        reset_dut;
        write_mask(4'b0000);
        INT_FLAG = 1'b1; IRQ = 4'b0110;
        tick; tick;
        pulse_ack;
        checks++;
        if (st !== 6'b001010) begin
            errors++; $display("FAIL prio_first: got %b expected %b", st, 6'b001010);
        end
        pulse_eoi;
        tick;
        checks++;
        if (INT !== 1'b1) begin
            errors++; $display("FAIL prio_rerequest: got INT=%b expected 1", INT);
        end
        pulse_ack;
`ifdef IRQ_EDGE_EN
        checks++;
        if (INT_VEC !== 3'd3) begin
            errors++; $display("FAIL prio_second: got %0d expected 3", INT_VEC);
        end
`else
        checks++;
        if (INT_VEC !== 3'd2) begin
            errors++; $display("FAIL prio_second: got %0d expected 2", INT_VEC);
        end
`endif
        IRQ = 4'b0000;
        pulse_eoi;
    endtask

    task automatic test_int_flag_nmi;
        reset_dut;
        write_mask(4'b0000);
        INT_FLAG = 1'b0; IRQ = 4'b0001;
        tick; tick; tick;
        checks++;
        if (st[5:4] !== 2'b00) begin
            errors++; $display("FAIL flag_block: got INT/NMI=%b expected 00", st[5:4]);
        end
        NMI_SRC = 1'b1;
        tick;
        checks++;
        if (NMI !== 1'b0) begin
            errors++; $display("FAIL nmi_latency1: got NMI=%b expected 0", NMI);
        end
        NMI_SRC = 1'b0;
        tick;
        checks++;
        if (st !== 6'b010000) begin
            errors++; $display("FAIL nmi_req: got %b expected %b", st, 6'b010000);
        end
        pulse_ack;
        checks++;
        if (st !== 6'b001000) begin
            errors++; $display("FAIL nmi_ack: got %b expected %b", st, 6'b001000);
        end
        pulse_eoi;
        IRQ = 4'b0000;
    endtask

    task automatic test_nested_nmi;
        reset_dut;
        write_mask(4'b0000);
        INT_FLAG = 1'b1; IRQ = 4'b0100;
        tick; tick;
        pulse_ack;
        checks++;
        if (st !== 6'b001011) begin
            errors++; $display("FAIL nest_irq2_ack: got %b expected %b", st, 6'b001011);
        end
        IRQ = 4'b0000; NMI_SRC = 1'b1;
        tick;
        NMI_SRC = 1'b0;
        tick;
        checks++;
        if (st !== 6'b011011) begin
            errors++; $display("FAIL nest_nmi_req: got %b expected %b", st, 6'b011011);
        end
        pulse_ack;
        checks++;
        if (st !== 6'b001000) begin
            errors++; $display("FAIL nest_nmi_ack: got %b expected %b", st, 6'b001000);
        end
        pulse_eoi;
        checks++;
        if (st[5:3] !== 3'b000) begin
            errors++; $display("FAIL nest_eoi: got %b expected 000", st[5:3]);
        end
    endtask

    task automatic test_simultaneous;
        reset_dut;
        write_mask(4'b0000);
        INT_FLAG = 1'b1; IRQ = 4'b0001; NMI_SRC = 1'b1;
        tick;
        NMI_SRC = 1'b0;
        tick;
        checks++;
        if (st !== 6'b010000) begin
            errors++; $display("FAIL simul_nmi_first: got %b expected %b", st, 6'b010000);
        end
        pulse_ack;
        checks++;
        if (st !== 6'b001000) begin
            errors++; $display("FAIL simul_nmi_ack: got %b expected %b", st, 6'b001000);
        end
        pulse_eoi;
        tick;
        checks++;
        if (st[5:3] !== 3'b100) begin
            errors++; $display("FAIL simul_irq_after: got %b expected 100", st[5:3]);
        end
        pulse_ack;
        checks++;
        if (st !== 6'b001001) begin
            errors++; $display("FAIL simul_irq_ack: got %b expected %b", st, 6'b001001);
        end
        IRQ = 4'b0000;
        pulse_eoi;
    endtask

    task automatic test_async_reset;
        reset_dut;
        write_mask(4'b0000);
        INT_FLAG = 1'b1; IRQ = 4'b0010;
        tick; tick;
        checks++;
        if (INT !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got INT=%b expected 1", INT);
        end
        #2;
        Rst_n = 1'b0;
        #1;
        checks++;
        if (st !== 6'b000000) begin
            errors++; $display("FAIL areset_async: got %b expected %b", st, 6'b000000);
        end
        IRQ = 4'b0000;
        tick;
        Rst_n = 1'b1;
        tick; tick; tick;
        checks++;
        if (st[5:4] !== 2'b00) begin
            errors++; $display("FAIL areset_no_pending: got INT/NMI=%b expected 00", st[5:4]);
        end
        IRQ = 4'b0001;
        tick; tick; tick;
        checks++;
        if (INT !== 1'b0) begin
            errors++; $display("FAIL areset_mask_ones: got INT=%b expected 0", INT);
        end
        IRQ = 4'b0000;
    endtask

    // Randomized run against a behavioural model of the request/service rules
    task automatic test_random;
        int         phase;   // 0 quiet, 1 NMI outstanding, 2 IRQ outstanding, 3 handler running
        int         nphase;
        int         vec;
        bit         insvc;
        bit         nmi_prev;
        bit         nmi_req;
        bit [3:0]   irq_prev;
        bit [3:0]   req;
        bit [3:0]   msk;
        int         best;
        int         served;
        bit         nmi_taken;
        logic [5:0] exp;

        reset_dut;
        phase = 0; vec = 0; insvc = 0; nmi_prev = 0; nmi_req = 0;
        irq_prev = '0; req = '0; msk = 4'hF;

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) IRQ = 4'($urandom);
            NMI_SRC  = ($urandom_range(0, 9) == 0);
            INT_FLAG = ($urandom_range(0, 7) != 0);
            MASK_WE  = ($urandom_range(0, 15) == 0);
            MASK_DIN = 4'($urandom) & 4'($urandom);
            INT_ACK  = ($urandom_range(0, 2) == 0);
            EOI      = ($urandom_range(0, 4) == 0);

            best = -1;
            for (int k = 0; k < 4; k++) begin
                if (best < 0 && req[k] && !msk[k] && INT_FLAG) best = k;
            end
            nphase = phase; served = -1; nmi_taken = 0;
            case (phase)
                0: begin
                    if (nmi_req) nphase = 1;
                    else if (best >= 0) nphase = 2;
                end
                1: begin
                    if (INT_ACK) begin
                        nphase = 3; vec = 0; insvc = 1; nmi_taken = 1;
                    end
                end
                2: begin
                    if (INT_ACK && best >= 0) begin
                        nphase = 3; vec = best + 1; insvc = 1; served = best;
                    end else if (nmi_req) nphase = 1;
                    else if (best < 0) nphase = 0;
                end
                default: begin
                    if (EOI) insvc = 0;
                    if (nmi_req) nphase = 1;
                    else if (EOI) nphase = 0;
                end
            endcase
            phase = nphase;
            if (nmi_taken) nmi_req = 0;
            if (NMI_SRC && !nmi_prev) nmi_req = 1;
`ifdef IRQ_EDGE_EN
            if (served >= 0) req[served] = 1'b0;
            req = req | (IRQ & ~irq_prev);
`else
            req = IRQ;
`endif
            irq_prev = IRQ;
            nmi_prev = NMI_SRC;
            if (MASK_WE) msk = MASK_DIN;

            tick;
            exp = {phase == 2, phase == 1, insvc, 3'(vec)};
            checks++;
            if (st !== exp) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b expected %b", c, st, exp);
            end
        end
        IRQ = '0; NMI_SRC = 1'b0; MASK_WE = 1'b0; INT_ACK = 1'b0; EOI = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_basic;
        test_priority;
        test_int_flag_nmi;
        test_nested_nmi;
        test_simultaneous;
        test_async_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
